// File: rtl/triumph_fetch_stage.sv
// triumph_fetch_stage: fetch PC owner, in-order imem req/gnt/rvalid master, FIFO_DEPTH-entry {instr,pc} buffer to decode.
// Ports: clk_i/rst_i (sync, active-high); pc_mux_i/branch_target_i redirect; imem_req_o/imem_addr_o/imem_gnt_i request;
// imem_rvalid_i/imem_rdata_i in-order response; instr_valid_o/instr_o/instr_pc_o/instr_ready_i decode handshake;
// fetch_misalign_o sticky misaligned-target flag, active only when TRIUMPH_FETCH_MISALIGN_CHK_EN is defined.
module triumph_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_mux_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        fetch_misalign_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] pc_q, tgt, rsp_pc;
  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] addr_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, out_q, drop_q;
  logic [CW:0] credit;
  logic mis_q, fire, rsp, push, pop;
  always_comb begin
    credit = {1'b0, cnt_q} + {1'b0, out_q};
    imem_req_o = !rst_i && !pc_mux_i && !mis_q && credit < (CW+1)'(FIFO_DEPTH);
    fire = imem_req_o && imem_gnt_i;
    rsp = imem_rvalid_i && out_q != '0;
    push = rsp && drop_q == '0;
    pop = cnt_q != '0 && instr_ready_i;
    // once drops are exhausted every in-flight request is post-redirect, so the oldest PC is pc_q minus 4 per outstanding
    rsp_pc = pc_q - 32'({out_q, 2'b00});
  end
  assign imem_addr_o = pc_q;
  assign instr_valid_o = cnt_q != '0;
  assign instr_o = instr_valid_o ? data_q[rd_q] : 32'h0;
  assign instr_pc_o = instr_valid_o ? addr_q[rd_q] : 32'h0;
  assign fetch_misalign_o = mis_q;
`ifdef TRIUMPH_FETCH_MISALIGN_CHK_EN
  assign tgt = branch_target_i;
  always_ff @(posedge clk_i) mis_q <= rst_i ? 1'b0 : pc_mux_i ? |branch_target_i[1:0] : mis_q;
`else
  assign tgt = {branch_target_i[31:2], 2'b00};
  assign mis_q = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      out_q <= out_q + CW'(fire) - CW'(rsp);
      if (pc_mux_i) begin
        pc_q <= tgt;
        wr_q <= '0;
        rd_q <= '0;
        cnt_q <= '0;
        drop_q <= out_q + CW'(fire) - CW'(rsp);
      end else begin
        if (fire) pc_q <= pc_q + 32'd4;
        if (rsp && drop_q != '0) drop_q <= drop_q - CW'(1);
        if (push) begin
          data_q[wr_q] <= imem_rdata_i;
          addr_q[wr_q] <= rsp_pc;
          wr_q <= wr_q + AW'(1);
        end
        if (pop) rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end
  always @(posedge clk_i)
    if (!rst_i && imem_rvalid_i) assert (out_q != '0) else $error("rvalid with no outstanding request");
endmodule

// File: tb/tb_triumph_fetch_stage.sv
// tb_triumph_fetch_stage: randomized and directed checks of triumph_fetch_stage against an expected PC-stream model.
module tb_triumph_fetch_stage;
  logic clk_i = 0;
  logic rst_i, pc_mux_i, imem_req_o, imem_gnt_i, imem_rvalid_i, instr_valid_o, instr_ready_i, fetch_misalign_o;
  logic [31:0] branch_target_i, imem_addr_o, imem_rdata_i, instr_o, instr_pc_o;
  logic w_gnt, w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_instr, w_pc;
  int total = 0, bad = 0;
  int gnt_mode, rv_mode, cnum, pops, granted;
  bit pend;
  logic [31:0] exp_fetch, exp_pc;
  logic [31:0] mq_addr[$];
  int mq_cyc[$];
  always #5 clk_i = ~clk_i;
  triumph_fetch_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_mux_i(pc_mux_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i),
    .fetch_misalign_o(fetch_misalign_o)
  );
  triumph_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .pc_mux_i(1'b0), .branch_target_i(32'h0),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
    .imem_rvalid_i(1'b0), .imem_rdata_i(32'h0), .instr_valid_o(w_valid),
    .instr_o(w_instr), .instr_pc_o(w_pc), .instr_ready_i(1'b0),
    .fetch_misalign_o(w_mis)
  );
  function automatic logic [31:0] hashf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] eff(input logic [31:0] t);
`ifdef TRIUMPH_FETCH_MISALIGN_CHK_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction
  task automatic cyc();
    imem_rvalid_i = 0;
    imem_rdata_i = 0;
    if (mq_addr.size() != 0 && mq_cyc[0] < cnum && (rv_mode == 1 || (rv_mode == 2 && $urandom_range(1, 0) == 1))) begin
      imem_rvalid_i = 1;
      imem_rdata_i = hashf(mq_addr[0]);
    end
    imem_gnt_i = gnt_mode == 1 ? 1'b1 : gnt_mode == 2 ? 1'($urandom_range(1, 0)) : 1'b0;
    #1;
    if (pend && !pc_mux_i) begin
      total++;
      if (imem_req_o !== 1'b1) begin bad++; $display("FAIL req_hold: req=%b want 1", imem_req_o); end
    end
    pend = imem_req_o && !imem_gnt_i;
    if (imem_rvalid_i) begin void'(mq_addr.pop_front()); void'(mq_cyc.pop_front()); end
    if (imem_req_o && imem_gnt_i) begin
      total++;
      if (imem_addr_o !== exp_fetch) begin bad++; $display("FAIL fetch_addr: got %h want %h", imem_addr_o, exp_fetch); end
      mq_addr.push_back(imem_addr_o);
      mq_cyc.push_back(cnum);
      exp_fetch += 4;
      granted++;
    end
    if (instr_valid_o && instr_ready_i && !pc_mux_i) begin
      total++;
      if (instr_pc_o !== exp_pc || instr_o !== hashf(exp_pc)) begin
        bad++; $display("FAIL pop: got pc=%h instr=%h want pc=%h instr=%h", instr_pc_o, instr_o, exp_pc, hashf(exp_pc));
      end
      exp_pc += 4;
      pops++;
    end
    if (pc_mux_i) begin
      total++;
      if (imem_req_o !== 1'b0) begin bad++; $display("FAIL redirect_req: req=%b want 0", imem_req_o); end
      exp_fetch = eff(branch_target_i);
      exp_pc = eff(branch_target_i);
    end
    cnum++;
    @(negedge clk_i);
  endtask
  task automatic do_reset();
    rst_i = 1; pc_mux_i = 0; branch_target_i = 0; instr_ready_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0; w_gnt = 0;
    gnt_mode = 0; rv_mode = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    mq_addr.delete(); mq_cyc.delete();
    exp_fetch = 0; exp_pc = 0; cnum = 0; pops = 0; granted = 0; pend = 0;
  endtask
  task automatic test_reset();
    rst_i = 1; pc_mux_i = 1; branch_target_i = 32'h102; imem_gnt_i = 1;
    imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF; instr_ready_i = 1; w_gnt = 1;
    repeat (2) @(negedge clk_i);
    #1;
    total++;
    if ({imem_req_o, instr_valid_o, fetch_misalign_o, instr_o, instr_pc_o} !== 67'h0) begin
      bad++; $display("FAIL reset_outputs: req=%b valid=%b mis=%b instr=%h pc=%h want all 0", imem_req_o, instr_valid_o, fetch_misalign_o, instr_o, instr_pc_o);
    end
    do_reset();
    #1;
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || instr_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_release: req=%b addr=%h valid=%b want 1 00000000 0", imem_req_o, imem_addr_o, instr_valid_o);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    #1;
    total++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap0: req=%b addr=%h want 1 fffffff8", w_req, w_addr); end
    w_gnt = 1;
    @(negedge clk_i); #1;
    total++;
    if (w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap1: addr=%h want fffffffc", w_addr); end
    @(negedge clk_i); #1;
    total++;
    if (w_addr !== 32'h0) begin bad++; $display("FAIL wrap2: addr=%h want 00000000", w_addr); end
    w_gnt = 0;
  endtask
  task automatic test_stream();
    do_reset();
    gnt_mode = 1; rv_mode = 1; instr_ready_i = 1;
    repeat (2) cyc();
    total++;
    if (pops !== 0) begin bad++; $display("FAIL stream_latency: pops=%0d want 0", pops); end
    repeat (18) cyc();
    total++;
    if (pops !== 18) begin bad++; $display("FAIL stream_throughput: pops=%0d want 18", pops); end
  endtask
  task automatic test_backpressure();
    do_reset();
    gnt_mode = 1; rv_mode = 1; instr_ready_i = 0;
    repeat (10) cyc();
    #1;
    total++;
    if (granted !== 4 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0) begin
      bad++; $display("FAIL backpressure: grants=%0d req=%b valid=%b pc=%h want 4 0 1 00000000", granted, imem_req_o, instr_valid_o, instr_pc_o);
    end
    instr_ready_i = 1;
    repeat (10) cyc();
    total++;
    if (pops < 8) begin bad++; $display("FAIL backpressure_restart: pops=%0d want >=8", pops); end
  endtask
  task automatic test_redirect();
    int p0;
    do_reset();
    gnt_mode = 1; rv_mode = 1; instr_ready_i = 1;
    for (int i = 0; i < 20 && exp_fetch != 32'h20; i++) cyc();
    gnt_mode = 0;
    repeat (4) cyc();
    rv_mode = 0; gnt_mode = 1;
    repeat (2) cyc();
    gnt_mode = 0; pc_mux_i = 1; branch_target_i = 32'h100;
    cyc();
    pc_mux_i = 0;
    #1;
    total++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      bad++; $display("FAIL redirect: valid=%b req=%b addr=%h want 0 1 00000100", instr_valid_o, imem_req_o, imem_addr_o);
    end
    rv_mode = 1; gnt_mode = 1; p0 = pops;
    repeat (10) cyc();
    total++;
    if (pops - p0 < 6) begin bad++; $display("FAIL redirect_refill: pops=%0d want >=6", pops - p0); end
  endtask
  task automatic test_redirect_rvalid_pop();
    do_reset();
    gnt_mode = 1; rv_mode = 0; instr_ready_i = 0;
    repeat (6) cyc();
    total++;
    if (granted !== 4) begin bad++; $display("FAIL rrp_grants: grants=%0d want 4", granted); end
    gnt_mode = 0; rv_mode = 1;
    cyc();
    pc_mux_i = 1; branch_target_i = 32'h300; instr_ready_i = 1;
    #1;
    total++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0) begin bad++; $display("FAIL rrp_head: valid=%b pc=%h want 1 00000000", instr_valid_o, instr_pc_o); end
    cyc();
    pc_mux_i = 0;
    #1;
    total++;
    if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rrp_flush: valid=%b want 0", instr_valid_o); end
    gnt_mode = 1;
    repeat (12) cyc();
    total++;
    if (pops < 6) begin bad++; $display("FAIL rrp_refill: pops=%0d want >=6", pops); end
  endtask
  task automatic test_misalign();
    do_reset();
    gnt_mode = 1; rv_mode = 1; instr_ready_i = 1;
    repeat (3) cyc();
    pc_mux_i = 1; branch_target_i = 32'h102;
    cyc();
    pc_mux_i = 0;
`ifdef TRIUMPH_FETCH_MISALIGN_CHK_EN
    begin
      int g0;
      g0 = granted;
      repeat (5) cyc();
      #1;
      total++;
      if (fetch_misalign_o !== 1'b1 || granted !== g0 || imem_req_o !== 1'b0) begin
        bad++; $display("FAIL misalign_block: mis=%b grants=%0d req=%b want 1 %0d 0", fetch_misalign_o, granted, imem_req_o, g0);
      end
      pc_mux_i = 1; branch_target_i = 32'h200;
      cyc();
      pc_mux_i = 0;
      #1;
      total++;
      if (fetch_misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
        bad++; $display("FAIL misalign_clear: mis=%b req=%b addr=%h want 0 1 00000200", fetch_misalign_o, imem_req_o, imem_addr_o);
      end
    end
`else
    #1;
    total++;
    if (fetch_misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      bad++; $display("FAIL misalign_force: mis=%b req=%b addr=%h want 0 1 00000100", fetch_misalign_o, imem_req_o, imem_addr_o);
    end
`endif
    repeat (4) cyc();
  endtask
  task automatic test_random();
    do_reset();
    gnt_mode = 2; rv_mode = 2;
    repeat (600) begin
      instr_ready_i = $urandom_range(3, 0) != 0;
      pc_mux_i = $urandom_range(19, 0) == 0;
      branch_target_i = $urandom & 32'hFFFF_FFFC;
      cyc();
    end
    pc_mux_i = 0; gnt_mode = 0; rv_mode = 1; instr_ready_i = 1;
    repeat (10) cyc();
    #1;
    total++;
    if (mq_addr.size() != 0 || instr_valid_o !== 1'b0 || pops < 50) begin
      bad++; $display("FAIL random_drain: inflight=%0d valid=%b pops=%0d want 0 0 >=50", mq_addr.size(), instr_valid_o, pops);
    end
  endtask
  initial begin
    test_reset();
    test_wrap();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_rvalid_pop();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
